// File: rtl/ysyx_22040750_axi_rd_arbiter_pkg.sv
// Shared definitions for the three-requester AXI read arbiter: FSM states,
// requester ids and the round-robin rotation helper.
package ysyx_22040750_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    localparam int NUM_CH = 3;

    localparam logic [1:0] CH_ICACHE   = 2'd0;
    localparam logic [1:0] CH_DCACHE   = 2'd1;
    localparam logic [1:0] CH_UNCACHED = 2'd2;

    // Next requester in rotation order; the unused code 3 folds back to ch0.
    function automatic logic [1:0] rr_next(input logic [1:0] ch);
        logic [1:0] nxt;
        if (ch >= CH_UNCACHED) begin
            nxt = CH_ICACHE;
        end else begin
            nxt = ch + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ysyx_22040750_axi_rd_arbiter_rr_arb3.sv
// Combinational 3-way round-robin picker: the search starts at the requester
// after 'last' and wraps, so the most recently served one has lowest priority.
module ysyx_22040750_rr_arb3
    import ysyx_22040750_axi_rd_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt,
    output logic       any
);

    logic [3:0] req_ext;
    logic [1:0] cand;
    logic       found;

    assign req_ext = {1'b0, req};
    assign any     = |req;

    always_comb begin
        gnt   = CH_ICACHE;
        found = 1'b0;
        cand  = last;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = rr_next(cand);
            if (!found && req_ext[cand]) begin
                gnt   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22040750_axi_rd_arbiter.sv
// Shares one AXI4 AR/R master port between icache refill (ch0), dcache refill
// (ch1) and uncached loads (ch2); one burst outstanding, grant held until rlast.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transaction; pick next requester if any arvalid is high
// ST_AR   | granted requester's AR routed to the bus until handshake
// ST_R    | bus R beats routed to granted requester until rlast handshake
module ysyx_22040750_axi_rd_arbiter
    import ysyx_22040750_axi_rd_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          I_clk,
    input  logic          I_rst,

    input  logic [AW-1:0] I_ch0_araddr,
    input  logic          I_ch0_arvalid,
    input  logic [7:0]    I_ch0_arlen,
    input  logic [2:0]    I_ch0_arsize,
    input  logic [1:0]    I_ch0_arburst,
    output logic          O_ch0_arready,
    output logic [DW-1:0] O_ch0_rdata,
    output logic          O_ch0_rvalid,
    output logic          O_ch0_rlast,
    input  logic          I_ch0_rready,

    input  logic [AW-1:0] I_ch1_araddr,
    input  logic          I_ch1_arvalid,
    input  logic [7:0]    I_ch1_arlen,
    input  logic [2:0]    I_ch1_arsize,
    input  logic [1:0]    I_ch1_arburst,
    output logic          O_ch1_arready,
    output logic [DW-1:0] O_ch1_rdata,
    output logic          O_ch1_rvalid,
    output logic          O_ch1_rlast,
    input  logic          I_ch1_rready,

    input  logic [AW-1:0] I_ch2_araddr,
    input  logic          I_ch2_arvalid,
    input  logic [7:0]    I_ch2_arlen,
    input  logic [2:0]    I_ch2_arsize,
    input  logic [1:0]    I_ch2_arburst,
    output logic          O_ch2_arready,
    output logic [DW-1:0] O_ch2_rdata,
    output logic          O_ch2_rvalid,
    output logic          O_ch2_rlast,
    input  logic          I_ch2_rready,

    output logic [AW-1:0] O_axi_araddr,
    output logic          O_axi_arvalid,
    output logic [7:0]    O_axi_arlen,
    output logic [2:0]    O_axi_arsize,
    output logic [1:0]    O_axi_arburst,
    input  logic          I_axi_arready,
    input  logic [DW-1:0] I_axi_rdata,
    input  logic          I_axi_rvalid,
    input  logic          I_axi_rlast,
    output logic          O_axi_rready
);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_q,  last_d;

    logic [AW-1:0] ch_araddr  [NUM_CH];
    logic [7:0]    ch_arlen   [NUM_CH];
    logic [2:0]    ch_arsize  [NUM_CH];
    logic [1:0]    ch_arburst [NUM_CH];
    logic [DW-1:0] ch_rdata   [NUM_CH];
    logic [2:0]    ch_arvalid;
    logic [2:0]    ch_rready;
    logic [2:0]    ch_arready;
    logic [2:0]    ch_rvalid;
    logic [2:0]    ch_rlast;

    logic [1:0]    pick_gnt;
    logic          pick_any;
    logic          axi_ar_fire;
    logic          axi_r_done;

    assign ch_araddr[0]  = I_ch0_araddr;
    assign ch_araddr[1]  = I_ch1_araddr;
    assign ch_araddr[2]  = I_ch2_araddr;
    assign ch_arlen[0]   = I_ch0_arlen;
    assign ch_arlen[1]   = I_ch1_arlen;
    assign ch_arlen[2]   = I_ch2_arlen;
    assign ch_arsize[0]  = I_ch0_arsize;
    assign ch_arsize[1]  = I_ch1_arsize;
    assign ch_arsize[2]  = I_ch2_arsize;
    assign ch_arburst[0] = I_ch0_arburst;
    assign ch_arburst[1] = I_ch1_arburst;
    assign ch_arburst[2] = I_ch2_arburst;
    assign ch_arvalid    = {I_ch2_arvalid, I_ch1_arvalid, I_ch0_arvalid};
    assign ch_rready     = {I_ch2_rready, I_ch1_rready, I_ch0_rready};

    ysyx_22040750_rr_arb3 u_rr_arb3 (
        .req  (ch_arvalid),
        .last (last_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    // Bus-side muxing and return routing; everything is zero outside the
    // state that owns it so stray R traffic never reaches a requester.
    always_comb begin
        O_axi_araddr  = '0;
        O_axi_arvalid = 1'b0;
        O_axi_arlen   = '0;
        O_axi_arsize  = '0;
        O_axi_arburst = '0;
        O_axi_rready  = 1'b0;
        ch_arready    = '0;
        ch_rvalid     = '0;
        ch_rlast      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rdata[i] = '0;
        end
        case (state_q)
            ST_AR: begin
                O_axi_araddr        = ch_araddr[grant_q];
                O_axi_arvalid       = ch_arvalid[grant_q];
                O_axi_arlen         = ch_arlen[grant_q];
                O_axi_arsize        = ch_arsize[grant_q];
                O_axi_arburst       = ch_arburst[grant_q];
                ch_arready[grant_q] = I_axi_arready;
            end
            ST_R: begin
                O_axi_rready        = ch_rready[grant_q];
                ch_rdata[grant_q]   = I_axi_rdata;
                ch_rvalid[grant_q]  = I_axi_rvalid;
                ch_rlast[grant_q]   = I_axi_rlast;
            end
            default: begin
            end
        endcase
    end

    assign axi_ar_fire = (state_q == ST_AR) && O_axi_arvalid && I_axi_arready;
    assign axi_r_done  = (state_q == ST_R) && I_axi_rvalid && O_axi_rready && I_axi_rlast;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                // A requester dropping arvalid here is a protocol error; we simply wait.
                if (axi_ar_fire) begin
                    last_d  = grant_q;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (axi_r_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            grant_q <= CH_ICACHE;
            last_q  <= CH_UNCACHED;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign O_ch0_arready = ch_arready[0];
    assign O_ch1_arready = ch_arready[1];
    assign O_ch2_arready = ch_arready[2];
    assign O_ch0_rvalid  = ch_rvalid[0];
    assign O_ch1_rvalid  = ch_rvalid[1];
    assign O_ch2_rvalid  = ch_rvalid[2];
    assign O_ch0_rlast   = ch_rlast[0];
    assign O_ch1_rlast   = ch_rlast[1];
    assign O_ch2_rlast   = ch_rlast[2];
    assign O_ch0_rdata   = ch_rdata[0];
    assign O_ch1_rdata   = ch_rdata[1];
    assign O_ch2_rdata   = ch_rdata[2];

endmodule

// File: tb/tb_ysyx_22040750_axi_rd_arbiter.sv
// Directed bench for the three-requester AXI read arbiter; the bench plays
// both the requesters and the AXI slave and checks routing cycle by cycle.
module tb_ysyx_22040750_axi_rd_arbiter;
    import ysyx_22040750_axi_rd_arbiter_pkg::*;

    logic        I_clk;
    logic        I_rst;
    logic [2:0]  ch_arvalid;
    logic [2:0]  ch_rready;
    logic [31:0] ch_araddr  [3];
    logic [7:0]  ch_arlen   [3];
    logic [2:0]  ch_arsize  [3];
    logic [1:0]  ch_arburst [3];

    wire  [2:0]  arready_o;
    wire  [2:0]  rvalid_o;
    wire  [2:0]  rlast_o;
    wire  [63:0] rdata_o [3];

    wire  [31:0] O_axi_araddr;
    wire         O_axi_arvalid;
    wire  [7:0]  O_axi_arlen;
    wire  [2:0]  O_axi_arsize;
    wire  [1:0]  O_axi_arburst;
    wire         O_axi_rready;
    logic        I_axi_arready;
    logic [63:0] I_axi_rdata;
    logic        I_axi_rvalid;
    logic        I_axi_rlast;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22040750_axi_rd_arbiter #(.AW(32), .DW(64)) dut (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_ch0_araddr  (ch_araddr[0]),
        .I_ch0_arvalid (ch_arvalid[0]),
        .I_ch0_arlen   (ch_arlen[0]),
        .I_ch0_arsize  (ch_arsize[0]),
        .I_ch0_arburst (ch_arburst[0]),
        .O_ch0_arready (arready_o[0]),
        .O_ch0_rdata   (rdata_o[0]),
        .O_ch0_rvalid  (rvalid_o[0]),
        .O_ch0_rlast   (rlast_o[0]),
        .I_ch0_rready  (ch_rready[0]),
        .I_ch1_araddr  (ch_araddr[1]),
        .I_ch1_arvalid (ch_arvalid[1]),
        .I_ch1_arlen   (ch_arlen[1]),
        .I_ch1_arsize  (ch_arsize[1]),
        .I_ch1_arburst (ch_arburst[1]),
        .O_ch1_arready (arready_o[1]),
        .O_ch1_rdata   (rdata_o[1]),
        .O_ch1_rvalid  (rvalid_o[1]),
        .O_ch1_rlast   (rlast_o[1]),
        .I_ch1_rready  (ch_rready[1]),
        .I_ch2_araddr  (ch_araddr[2]),
        .I_ch2_arvalid (ch_arvalid[2]),
        .I_ch2_arlen   (ch_arlen[2]),
        .I_ch2_arsize  (ch_arsize[2]),
        .I_ch2_arburst (ch_arburst[2]),
        .O_ch2_arready (arready_o[2]),
        .O_ch2_rdata   (rdata_o[2]),
        .O_ch2_rvalid  (rvalid_o[2]),
        .O_ch2_rlast   (rlast_o[2]),
        .I_ch2_rready  (ch_rready[2]),
        .O_axi_araddr  (O_axi_araddr),
        .O_axi_arvalid (O_axi_arvalid),
        .O_axi_arlen   (O_axi_arlen),
        .O_axi_arsize  (O_axi_arsize),
        .O_axi_arburst (O_axi_arburst),
        .I_axi_arready (I_axi_arready),
        .I_axi_rdata   (I_axi_rdata),
        .I_axi_rvalid  (I_axi_rvalid),
        .I_axi_rlast   (I_axi_rlast),
        .O_axi_rready  (O_axi_rready)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input int ch, input int b);
        return 64'hD000_0000_0000_0000 | (64'(ch) << 8) | 64'(b);
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_arvalid"}, 64'(O_axi_arvalid), 64'd0);
        check_val({tag, "_araddr"},  64'(O_axi_araddr),  64'd0);
        check_val({tag, "_arlen"},   64'(O_axi_arlen),   64'd0);
        check_val({tag, "_arsize"},  64'(O_axi_arsize),  64'd0);
        check_val({tag, "_arburst"}, 64'(O_axi_arburst), 64'd0);
        check_val({tag, "_rready"},  64'(O_axi_rready),  64'd0);
        check_val({tag, "_arready"}, 64'(arready_o),     64'd0);
        check_val({tag, "_rvalid"},  64'(rvalid_o),      64'd0);
        check_val({tag, "_rlast"},   64'(rlast_o),       64'd0);
        check_val({tag, "_rdata0"},  rdata_o[0],         64'd0);
        check_val({tag, "_state"},   64'(dut.state_q),   64'(ST_IDLE));
    endtask

    task automatic do_reset();
        I_rst = 1'b1;
        tick();
        tick();
        I_rst = 1'b0;
    endtask

    task automatic request(input int ch, input logic [31:0] addr, input logic [7:0] len);
        ch_araddr[ch]  = addr;
        ch_arlen[ch]   = len;
        ch_arvalid[ch] = 1'b1;
    endtask

    // Expects the AR for 'ch' to appear exactly one cycle after the call, then handshakes it.
    task automatic ar_phase(input int ch);
        int n;
        n = 0;
        #1;
        while (!O_axi_arvalid && n < 20) begin
            tick();
            n++;
        end
        check_val("ar_latency", 64'(n), 64'd1);
        check_val("ar_addr",    64'(O_axi_araddr),  64'(ch_araddr[ch]));
        check_val("ar_len",     64'(O_axi_arlen),   64'(ch_arlen[ch]));
        check_val("ar_size",    64'(O_axi_arsize),  64'(ch_arsize[ch]));
        check_val("ar_burst",   64'(O_axi_arburst), 64'(ch_arburst[ch]));
        check_val("ar_rdy_low", 64'(arready_o),     64'd0);
        I_axi_arready = 1'b1;
        #1;
        check_val("ar_rdy_route", 64'(arready_o), 64'(3'b001 << ch));
        tick();
        ch_arvalid[ch] = 1'b0;
        I_axi_arready  = 1'b0;
    endtask

    task automatic r_phase(input int ch, input int beats, input bit toggle);
        int got;
        int cyc;
        logic last_beat;
        got = 0;
        cyc = 0;
        while (got < beats && cyc < 40) begin
            last_beat     = (got == beats - 1);
            I_axi_rvalid  = 1'b1;
            I_axi_rdata   = beat_data(ch, got);
            I_axi_rlast   = last_beat;
            ch_rready[ch] = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            check_val("r_rready",  64'(O_axi_rready), 64'(ch_rready[ch]));
            check_val("r_rvalid",  64'(rvalid_o),     64'(3'b001 << ch));
            check_val("r_rdata",   rdata_o[ch],       beat_data(ch, got));
            check_val("r_rlast",   64'(rlast_o),      last_beat ? 64'(3'b001 << ch) : 64'd0);
            check_val("r_arready", 64'(arready_o),    64'd0);
            check_val("r_no_ar",   64'(O_axi_arvalid), 64'd0);
            if (ch_rready[ch]) got++;
            cyc++;
            tick();
        end
        check_val("r_beats", 64'(got), 64'(beats));
        I_axi_rvalid = 1'b0;
        I_axi_rlast  = 1'b0;
        ch_rready    = '0;
        #1;
        check_val("r_end_state",  64'(dut.state_q), 64'(ST_IDLE));
        check_val("r_end_rvalid", 64'(rvalid_o),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        I_rst         = 1'b1;
        ch_arvalid    = '0;
        ch_rready     = '0;
        I_axi_arready = 1'b0;
        I_axi_rdata   = '0;
        I_axi_rvalid  = 1'b0;
        I_axi_rlast   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ch_araddr[i]  = '0;
            ch_arlen[i]   = '0;
            ch_arsize[i]  = 3'd3;
            ch_arburst[i] = 2'd1;
        end
        ch_arsize[2]  = 3'd2;
        ch_arburst[2] = 2'd0;
        tick();
        tick();
        check_quiet("rst");
        I_rst = 1'b0;
        tick();

        // single burst on ch0
        request(0, 32'h8000_0000, 8'd1);
        ar_phase(0);
        r_phase(0, 2, 1'b0);

        // three simultaneous requesters after reset: served 0, 1, 2
        do_reset();
        request(0, 32'h8000_0100, 8'd1);
        request(1, 32'h8000_0200, 8'd0);
        request(2, 32'h1000_0004, 8'd0);
        ar_phase(0);
        r_phase(0, 2, 1'b0);
        ar_phase(1);
        r_phase(1, 1, 1'b0);
        ar_phase(2);
        r_phase(2, 1, 1'b0);

        // ch2 arrives while ch0 holds the bus and must wait for rlast
        request(0, 32'h8000_0300, 8'd2);
        ar_phase(0);
        request(2, 32'h1000_0008, 8'd0);
        r_phase(0, 3, 1'b0);
        ar_phase(2);
        r_phase(2, 1, 1'b0);

        // ch1 with toggling rready
        request(1, 32'h8000_0400, 8'd3);
        ar_phase(1);
        r_phase(1, 4, 1'b1);

        // stray R traffic while idle
        I_axi_rvalid = 1'b1;
        I_axi_rlast  = 1'b1;
        I_axi_rdata  = 64'hDEAD_BEEF_0000_0001;
        #1;
        check_quiet("stray");
        tick();
        check_quiet("stray2");
        I_axi_rvalid = 1'b0;
        I_axi_rlast  = 1'b0;

        // reset on beat 2 of 4; afterwards ch0 must win over ch1 again
        request(0, 32'h8000_0500, 8'd3);
        ar_phase(0);
        I_axi_rvalid = 1'b1;
        I_axi_rlast  = 1'b0;
        I_axi_rdata  = beat_data(0, 0);
        ch_rready[0] = 1'b1;
        tick();
        I_axi_rdata = beat_data(0, 1);
        I_rst       = 1'b1;
        #1;
        check_val("mid_beat2", rdata_o[0], beat_data(0, 1));
        tick();
        I_rst = 1'b0;
        check_quiet("mid_rst");
        I_axi_rvalid = 1'b0;
        ch_rready    = '0;
        request(0, 32'h8000_0600, 8'd0);
        request(1, 32'h8000_0700, 8'd0);
        ar_phase(0);
        r_phase(0, 1, 1'b0);
        ar_phase(1);
        r_phase(1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
